// File: rtl/hazard_ctrl_unit.sv
// Hazard unit for the 5-stage RISC-V pipeline: forwarding, load-use stall, branch flush and a
// multi-cycle data-memory wait FSM. Define HAZARD_PERF_EN to build the stall/flush cycle counters.
module hazard_ctrl_unit #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] RS1_D,
  input  logic [REG_ADDR_W-1:0] RS2_D,
  input  logic [REG_ADDR_W-1:0] RS1_E,
  input  logic [REG_ADDR_W-1:0] RS2_E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic                  ResultSrcE,
  input  logic                  PCSrcE,
  input  logic [REG_ADDR_W-1:0] RD_M,
  input  logic [REG_ADDR_W-1:0] RD_W,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  mem_req_m,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic [CNT_W-1:0]      PerfStallCnt,
  output logic [CNT_W-1:0]      PerfFlushCnt
);

  localparam int unsigned     WcntW      = $clog2(MEM_LATENCY) + 1;
  localparam logic [WcntW-1:0] WcntLast  = WcntW'(MEM_LATENCY - 1);
  localparam bit              MultiCycle = (MEM_LATENCY > 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e           state_q, state_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic             mem_stall;
  logic             lw_stall;
  logic             hit_m_a, hit_w_a, hit_m_b, hit_w_b;

  // Memory-wait FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Memory-wait FSM: next state
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      StIdle: begin
        if (mem_req_m && MultiCycle) begin
          state_d = StWait;
          wcnt_d  = WcntW'(1);
        end
      end
      StWait: begin
        if (wcnt_q == WcntLast) begin
          state_d = StIdle;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        wcnt_d  = '0;
      end
    endcase
  end

  // Memory-wait FSM: output; the last WAIT cycle releases so the access leaves M at that edge
  always_comb begin
    mem_stall = 1'b0;
    unique case (state_q)
      StIdle:  mem_stall = mem_req_m && MultiCycle;
      StWait:  mem_stall = (wcnt_q != WcntLast);
      default: mem_stall = 1'b0;
    endcase
  end

  always_comb begin
    hit_m_a  = RegWriteM && (RD_M != '0) && (RD_M == RS1_E);
    hit_w_a  = RegWriteW && (RD_W != '0) && (RD_W == RS1_E);
    hit_m_b  = RegWriteM && (RD_M != '0) && (RD_M == RS2_E);
    hit_w_b  = RegWriteW && (RD_W != '0) && (RD_W == RS2_E);
    lw_stall = ResultSrcE && (RD_E != '0) && ((RD_E == RS1_D) || (RD_E == RS2_D));
  end

  // Every control output is held at zero while reset is asserted, independent of the clock.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (rst) begin
      if (hit_m_a)      ForwardAE = 2'b10;
      else if (hit_w_a) ForwardAE = 2'b01;
      if (hit_m_b)      ForwardBE = 2'b10;
      else if (hit_w_b) ForwardBE = 2'b01;

      if (mem_stall) begin
        // Whole pipe frozen; branch and load-use decisions wait for the release.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        FlushD = PCSrcE;
        FlushE = PCSrcE || lw_stall;
        StallF = lw_stall && !PCSrcE;
        StallD = lw_stall && !PCSrcE;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (FlushD && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign PerfStallCnt = stall_cnt_q;
  assign PerfFlushCnt = flush_cnt_q;
`else
  assign PerfStallCnt = '0;
  assign PerfFlushCnt = '0;
`endif

endmodule
